sa_psum_drain: RTL

//  Output-side consumer of the systolic array: captures the skewed per-column psums leaving the

---
 rtl/sa_psum_drain.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/sa_psum_drain.sv
// sa_psum_drain: de-skews bottom-row systolic psums into whole rows, buffers them and drains per job.
// Define SA_DRAIN_RELU_EN to clamp negative columns to zero (adds one pipeline stage).
module sa_psum_drain #(
    parameter int ADD_DATAWIDTH = 8,
    parameter int NUM_COLS      = 4,
    parameter int FIFO_DEPTH    = 4,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_start,
    input  logic [CNT_WIDTH-1:0]              i_num_rows,
    input  logic [NUM_COLS*ADD_DATAWIDTH-1:0] i_psum,
    input  logic [NUM_COLS-1:0]               i_psum_valid,
    output logic [NUM_COLS*ADD_DATAWIDTH-1:0] o_row,
    output logic                              o_row_valid,
    input  logic                              i_row_ready,
    output logic                              o_done,
    output logic                              o_skew_err,
    output logic                              o_overflow
);
    localparam int W  = ADD_DATAWIDTH;
    localparam int N  = NUM_COLS;
    localparam int RW = N * W;
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;
    state_t state;

    logic [RW-1:0] al_d, pd;
    logic [N-1:0]  al_v, pv;

    // Column c waits N-1-c cycles so that every column of a row lines up with the last column.
    genvar c;
    generate
        for (c = 0; c < N; c++) begin : g_col
            localparam int L = N - 1 - c;
            if (L == 0) begin : g_pass
                assign al_d[c*W +: W] = i_psum[c*W +: W];
                assign al_v[c]        = i_psum_valid[c];
            end else begin : g_dly
                logic [W-1:0] d [L];
                logic [L-1:0] v;
                always_ff @(posedge i_clk or posedge i_rst) begin
                    if (i_rst) begin
                        for (int k = 0; k < L; k++) d[k] <= '0;
                        v <= '0;
                    end else begin
                        d[0] <= i_psum[c*W +: W];
                        v[0] <= i_psum_valid[c] & ~i_start;
                        for (int k = 1; k < L; k++) begin
                            d[k] <= d[k-1];
                            v[k] <= v[k-1] & ~i_start;
                        end
                    end
                end
                assign al_d[c*W +: W] = d[L-1];
                assign al_v[c]        = v[L-1];
            end
        end
    endgenerate

`ifdef SA_DRAIN_RELU_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pd <= '0;
            pv <= '0;
        end else begin
            pv <= i_start ? '0 : al_v;
            for (int k = 0; k < N; k++)
                pd[k*W +: W] <= al_d[k*W + W - 1] ? '0 : al_d[k*W +: W];
        end
    end
`else
    assign pd = al_d;
    assign pv = al_v;
`endif

    logic [RW-1:0]    mem [FIFO_DEPTH];
    logic [AW:0]      cnt, cnt_n;
    logic [AW-1:0]    wr_ptr, rd_ptr, rd_n;
    logic [RW-1:0]    head_n;
    logic [CNT_WIDTH-1:0] num_rows, pushed, popped;
    logic             active, arrive, full, pop, push, skew;

    assign active      = state == DRAIN && !i_start;
    assign arrive      = active && (&pv) && pushed != num_rows;
    assign skew        = active && (|pv) && !(&pv);
    assign full        = cnt == (AW+1)'(FIFO_DEPTH);
    assign o_row_valid = |cnt;
    assign pop         = o_row_valid & i_row_ready;
    assign push        = arrive & (~full | pop);
    assign rd_n        = rd_ptr + AW'(pop);
    assign cnt_n       = cnt + (AW+1)'(push) - (AW+1)'(pop);
    // A row written this cycle into an otherwise empty FIFO becomes the new head directly.
    assign head_n      = (push && wr_ptr == rd_n) ? pd : mem[rd_n];

    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr] <= pd;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            o_row  <= '0;
        end else if (i_start) begin
            cnt    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            cnt    <= cnt_n;
            rd_ptr <= rd_n;
            wr_ptr <= wr_ptr + AW'(push);
            if (cnt_n != '0) o_row <= head_n;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            num_rows   <= '0;
            pushed     <= '0;
            popped     <= '0;
            o_done     <= 1'b0;
            o_skew_err <= 1'b0;
            o_overflow <= 1'b0;
        end else if (i_start) begin
            num_rows   <= i_num_rows;
            pushed     <= '0;
            popped     <= '0;
            o_skew_err <= 1'b0;
            o_overflow <= 1'b0;
            state      <= i_num_rows == '0 ? DONE : DRAIN;
            o_done     <= i_num_rows == '0;
        end else begin
            if (arrive) pushed <= pushed + CNT_WIDTH'(1);
            if (skew) o_skew_err <= 1'b1;
            if (arrive && full && !pop) o_overflow <= 1'b1;
            if (state == DRAIN && pop) begin
                popped <= popped + CNT_WIDTH'(1);
                if (popped + CNT_WIDTH'(1) == num_rows) begin
                    state  <= DONE;
                    o_done <= 1'b1;
                end
            end
        end
    end
endmodule
